// File: rtl/cdb_arbiter_pkg.sv
// Shared types for the common data bus arbiter: ROB tag, data word and the
// broadcast record, plus a small modulo-increment helper.
`ifndef CDB_REQUESTERS
`define CDB_REQUESTERS 4
`endif

package cdb_arbiter_pkg;

   localparam int ROB_TAG_W       = 6;
   localparam int WORD_W          = 32;
   localparam int CDB_REQ_DEFAULT = `CDB_REQUESTERS;

   typedef logic [ROB_TAG_W-1:0] RobSize;
   typedef logic [WORD_W-1:0]    MemoryWord;

   typedef struct packed {
      RobSize    tag;
      MemoryWord value;
   } cdb;

   function automatic int next_index(input int idx, input int n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/cdb_arbiter_fifo.sv
// Per-requester result buffer: DEPTH-entry circular FIFO with a synchronous
// clear used for mispredict squash.
module cdb_fifo
   import cdb_arbiter_pkg::*;
#(
   parameter  int DEPTH = 2,
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             push,
   input  logic             pop,
   input  cdb               din,
   output cdb               dout,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count
);

   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;
   cdb               mem [DEPTH];

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full && !clear;
   assign do_pop  = pop && !empty && !clear;
   assign dout    = mem[rd_ptr];

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= PTR_W'(next_index(int'(wr_ptr), DEPTH));
         if (do_pop)  rd_ptr <= PTR_W'(next_index(int'(rd_ptr), DEPTH));
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // NOTE: storage is deliberately not reset; count/pointers gate every read, so stale words are unreachable.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/cdb_arbiter.sv
// Two-slot common data bus arbiter: buffers results per functional unit and
// broadcasts up to two per cycle in round-robin order from rr_ptr.
module cdb_arbiter
   import cdb_arbiter_pkg::*;
#(
   parameter int NUM_REQ    = CDB_REQ_DEFAULT,
   parameter int FIFO_DEPTH = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic      [NUM_REQ-1:0] req_valid,
   input  RobSize    [NUM_REQ-1:0] req_tag,
   input  MemoryWord [NUM_REQ-1:0] req_value,
   output logic      [NUM_REQ-1:0] req_ready,
   input  logic                   flush,
   output cdb                     cdb1,
   output cdb                     cdb2,
   output logic                   pending
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

   logic [NUM_REQ-1:0] push;
   logic [NUM_REQ-1:0] pop;
   logic [NUM_REQ-1:0] full;
   logic [NUM_REQ-1:0] empty;
   cdb                 head [NUM_REQ];
   logic [CNT_W-1:0]   fifo_count [NUM_REQ];

   logic [IDX_W-1:0] rr_ptr;
   logic [IDX_W-1:0] rr_next;
   logic [IDX_W-1:0] g1_idx;
   logic [IDX_W-1:0] g2_idx;
   logic             g1_valid;
   logic             g2_valid;

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_fifo
      cdb din;

      // Tag 0 means "no result": such requests are silently dropped.
      assign req_ready[i] = !full[i];
      assign push[i]      = req_valid[i] && req_ready[i] && !flush && (req_tag[i] != '0);
      assign din          = '{tag: req_tag[i], value: req_value[i]};

      cdb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
         .clk   (clk),
         .reset (reset),
         .clear (flush),
         .push  (push[i]),
         .pop   (pop[i]),
         .din   (din),
         .dout  (head[i]),
         .full  (full[i]),
         .empty (empty[i]),
         .count (fifo_count[i])
      );

      always_ff @(posedge clk) begin
         if (reset) assert (empty[i] == (fifo_count[i] == '0));
      end
   end

   assign pending = |(~empty);

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      logic [IDX_W-1:0] sel;
      int               idx;
      g1_valid = 1'b0;
      g2_valid = 1'b0;
      g1_idx   = '0;
      g2_idx   = '0;
      pop      = '0;
      rr_next  = rr_ptr;
      sel      = '0;
      idx      = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = int'(rr_ptr) + k;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         sel = IDX_W'(idx);
         if (!flush && !empty[sel]) begin
            if (!g1_valid) begin
               g1_valid = 1'b1;
               g1_idx   = sel;
            end else if (!g2_valid) begin
               g2_valid = 1'b1;
               g2_idx   = sel;
            end
         end
      end
      if (g1_valid) pop[g1_idx] = 1'b1;
      if (g2_valid) pop[g2_idx] = 1'b1;
      if (g2_valid)      rr_next = IDX_W'(next_index(int'(g2_idx), NUM_REQ));
      else if (g1_valid) rr_next = IDX_W'(next_index(int'(g1_idx), NUM_REQ));
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rr_ptr <= '0;
         cdb1   <= '0;
         cdb2   <= '0;
      end else begin
         rr_ptr <= rr_next;
         cdb1   <= g1_valid ? head[g1_idx] : '0;
         cdb2   <= g2_valid ? head[g2_idx] : '0;
      end
   end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: cycle-exact vector table plus a
// per-requester scoreboard that every broadcast is matched against.
module tb_cdb_arbiter;
   import cdb_arbiter_pkg::*;

   localparam int N = 4;

   logic                clk = 1'b0;
   logic                reset;
   logic      [N-1:0]   req_valid;
   RobSize    [N-1:0]   req_tag;
   MemoryWord [N-1:0]   req_value;
   logic      [N-1:0]   req_ready;
   logic                flush;
   cdb                  cdb1;
   cdb                  cdb2;
   logic                pending;

   int n_checks = 0;
   int n_fail   = 0;
   cdb sb_q [N][$];

   typedef struct packed {
      logic [N-1:0]      valid;
      RobSize [N-1:0]    tags;
      logic              flush;
      RobSize            e1;
      RobSize            e2;
      logic              e_pend;
      logic [1:0]        e_rr;
   } vec_t;

   vec_t vecs [$];

   always #5 clk = ~clk;

   cdb_arbiter #(.NUM_REQ(N), .FIFO_DEPTH(2)) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_tag   (req_tag),
      .req_value (req_value),
      .req_ready (req_ready),
      .flush     (flush),
      .cdb1      (cdb1),
      .cdb2      (cdb2),
      .pending   (pending)
   );

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   function automatic MemoryWord val_of(input int r, input RobSize t);
      return {4'(r), 4'hA, 18'h0, t};
   endfunction

   function automatic vec_t mk(input logic [N-1:0] v, input int t0, input int t1, input int t2,
                               input int t3, input logic f, input int e1, input int e2,
                               input logic p, input int rr);
      vec_t x;
      x.valid   = v;
      x.tags[0] = RobSize'(t0);
      x.tags[1] = RobSize'(t1);
      x.tags[2] = RobSize'(t2);
      x.tags[3] = RobSize'(t3);
      x.flush   = f;
      x.e1      = RobSize'(e1);
      x.e2      = RobSize'(e2);
      x.e_pend  = p;
      x.e_rr    = 2'(rr);
      return x;
   endfunction

   task automatic drive(input logic [N-1:0] v, input RobSize [N-1:0] t);
      req_valid = v;
      req_tag   = t;
      for (int i = 0; i < N; i++) req_value[i] = val_of(i, t[i]);
   endtask

   task automatic idle();
      req_valid = '0;
      req_tag   = '0;
      req_value = '0;
   endtask

   task automatic observe(input cdb c, input string name);
      bit hit;
      hit = 1'b0;
      if (c.tag == '0) begin
         check({name, " idle value"}, 64'(c.value), 64'd0);
      end else begin
         for (int r = 0; r < N; r++) begin
            if (!hit && sb_q[r].size() > 0 && sb_q[r][0] == c) begin
               hit = 1'b1;
               sb_q[r].delete(0);
            end
         end
         n_checks++;
         if (!hit) begin
            n_fail++;
            $display("FAIL %s scoreboard actual tag=%0d value=0x%0h required=a queued result",
                     name, c.tag, c.value);
         end
      end
   endtask

   // Record accepted requests, advance one clock, then match the broadcasts.
   task automatic step();
      if (flush) begin
         for (int i = 0; i < N; i++) sb_q[i].delete();
      end else begin
         for (int i = 0; i < N; i++)
            if (req_valid[i] && req_ready[i] && req_tag[i] != '0)
               sb_q[i].push_back('{tag: req_tag[i], value: req_value[i]});
      end
      @(posedge clk);
      #1;
      observe(cdb1, "cdb1");
      observe(cdb2, "cdb2");
   endtask

   task automatic drain(input int max_cycles, input string name);
      int cnt;
      cnt = 0;
      while (pending && cnt < max_cycles) begin
         step();
         cnt++;
      end
      check({name, " drained"}, 64'(pending), 64'd0);
      for (int r = 0; r < N; r++)
         check($sformatf("%s queue%0d empty", name, r), 64'(sb_q[r].size()), 64'd0);
   endtask

   initial begin
      RobSize [N-1:0] t;
      int             acc0;
      int             cyc;
      logic           take;

      reset = 1'b0;
      flush = 1'b0;
      idle();
      #3;
      check("reset cdb1", 64'(cdb1), 64'd0);
      check("reset cdb2", 64'(cdb2), 64'd0);
      check("reset ready", 64'(req_ready), 64'hF);
      check("reset pending", 64'(pending), 64'd0);
      #19;
      reset = 1'b1;

      //         valid    t0  t1  t2  t3  fl  e1  e2  pend rr
      vecs.push_back(mk(4'b1111,  1,  2,  3,  4, 0,  0,  0, 1, 0));
      vecs.push_back(mk(4'b0000,  0,  0,  0,  0, 0,  1,  2, 1, 2));
      vecs.push_back(mk(4'b0000,  0,  0,  0,  0, 0,  3,  4, 0, 0));
      vecs.push_back(mk(4'b0000,  0,  0,  0,  0, 0,  0,  0, 0, 0));
      vecs.push_back(mk(4'b0001,  5,  0,  0,  0, 0,  0,  0, 1, 0));
      vecs.push_back(mk(4'b0001,  6,  0,  0,  0, 0,  5,  0, 1, 1));
      vecs.push_back(mk(4'b0001,  7,  0,  0,  0, 0,  6,  0, 1, 1));
      vecs.push_back(mk(4'b0000,  0,  0,  0,  0, 0,  7,  0, 0, 1));
      vecs.push_back(mk(4'b1110,  0,  8,  9, 10, 0,  0,  0, 1, 1));
      vecs.push_back(mk(4'b0000,  0,  0,  0,  0, 1,  0,  0, 0, 1));
      vecs.push_back(mk(4'b0010,  0,  0,  0,  0, 0,  0,  0, 0, 1));
      vecs.push_back(mk(4'b0000,  0,  0,  0,  0, 0,  0,  0, 0, 1));
      vecs.push_back(mk(4'b0001, 11,  0,  0,  0, 1,  0,  0, 0, 1));
      vecs.push_back(mk(4'b0000,  0,  0,  0,  0, 0,  0,  0, 0, 1));
      vecs.push_back(mk(4'b1111, 12, 13, 14, 15, 0,  0,  0, 1, 1));
      vecs.push_back(mk(4'b0000,  0,  0,  0,  0, 0, 13, 14, 1, 3));
      vecs.push_back(mk(4'b0000,  0,  0,  0,  0, 0, 15, 12, 0, 1));
      vecs.push_back(mk(4'b0000,  0,  0,  0,  0, 0,  0,  0, 0, 1));

      foreach (vecs[k]) begin
         drive(vecs[k].valid, vecs[k].tags);
         flush = vecs[k].flush;
         step();
         check($sformatf("v%0d cdb1.tag", k), 64'(cdb1.tag), 64'(vecs[k].e1));
         check($sformatf("v%0d cdb2.tag", k), 64'(cdb2.tag), 64'(vecs[k].e2));
         check($sformatf("v%0d pending", k), 64'(pending), 64'(vecs[k].e_pend));
         check($sformatf("v%0d ready", k), 64'(req_ready), 64'hF);
         check($sformatf("v%0d rr_ptr", k), 64'(dut.rr_ptr), 64'(vecs[k].e_rr));
      end
      flush = 1'b0;
      idle();

      // Tag-0 request is dropped without touching the FIFO.
      req_valid[1] = 1'b1;
      step();
      check("tag0 fifo1 count", 64'(dut.g_fifo[1].u_fifo.count), 64'd0);
      check("tag0 pending", 64'(pending), 64'd0);
      idle();

      // Backpressure on requester 0 while the others keep the bus busy.
      acc0 = 0;
      cyc  = 0;
      while (acc0 < 3 && cyc < 40) begin
         t[0] = RobSize'(acc0 + 1);
         for (int i = 1; i < N; i++) t[i] = RobSize'(20 + ((cyc * 3 + i) % 40));
         drive(4'hF, t);
         take = req_ready[0];
         step();
         cyc++;
         if (take) begin
            acc0++;
            if (acc0 == 1) check("bp ready0 after 1 accept", 64'(req_ready[0]), 64'd1);
            if (acc0 == 2) check("bp ready0 after 2 accepts", 64'(req_ready[0]), 64'd0);
         end
      end
      check("bp req0 accepted count", 64'(acc0), 64'd3);
      idle();
      drain(30, "bp");

      // Single result: visible two edges after presentation.
      req_valid[2] = 1'b1;
      req_tag[2]   = RobSize'(5);
      req_value[2] = 32'h1234;
      step();
      check("single cdb1 early", 64'(cdb1.tag), 64'd0);
      check("single pending", 64'(pending), 64'd1);
      idle();
      step();
      check("single cdb1", 64'(cdb1), 64'({RobSize'(5), 32'h0000_1234}));
      check("single cdb2.tag", 64'(cdb2.tag), 64'd0);
      check("single pending after", 64'(pending), 64'd0);

      // Asynchronous reset with buffered results.
      for (int c = 0; c < 3; c++) begin
         for (int i = 0; i < N; i++) t[i] = RobSize'(40 + c * N + i);
         drive(4'hF, t);
         step();
      end
      #2;
      reset = 1'b0;
      #1;
      check("async rst cdb1", 64'(cdb1), 64'd0);
      check("async rst cdb2", 64'(cdb2), 64'd0);
      check("async rst pending", 64'(pending), 64'd0);
      check("async rst ready", 64'(req_ready), 64'hF);
      for (int i = 0; i < N; i++) sb_q[i].delete();
      idle();
      #10;
      reset = 1'b1;

      req_valid[0] = 1'b1;
      req_tag[0]   = RobSize'(9);
      req_value[0] = val_of(0, RobSize'(9));
      step();
      check("post rst first edge cdb1", 64'(cdb1.tag), 64'd0);
      idle();
      step();
      check("post rst second edge cdb1", 64'(cdb1.tag), 64'd9);
      for (int c = 0; c < 3; c++) step();
      drain(10, "final");

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
